// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: UART transmitter with transmit FIFO and runtime-selectable frame format
module uart_tx_fifo_cfg #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W = 16,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tx_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic [1:0]       data_len_i,
    input  logic [1:0]       parity_i,
    input  logic             stop2_i,
    input  logic             break_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [7:0]       wr_data_i,
    output logic [CNT_W-1:0] level_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DIV_W-1:0] cnt;
    logic [2:0] idx, idx_n;
    logic stop_cnt, stop_n;
    logic [7:0] data_q;
    logic [1:0] len_q, par_q;
    logic stop2_q;
    logic push, pop, tick, empty, par_bit, tx_n;
    assign empty = level_o == '0;
    assign wr_ready_o = level_o != CNT_W'(FIFO_DEPTH);
    assign push = wr_valid_i && wr_ready_o;
    assign busy_o = state != IDLE;
    assign tick = busy_o && cnt == baud_div_i;
    assign par_bit = ^(data_q & (8'hFF >> (2'd3 - len_q))) ^ par_q[1];
    // FIFO storage; contents need no reset
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wr_data_i;
    end
    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level_o <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level_o <= level_o + CNT_W'(push) - CNT_W'(pop);
        end
    end
    // Frame state, baud counter, latched frame format and the registered line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            stop_cnt <= 1'b0;
            tx_o <= 1'b1;
            data_q <= '0;
            len_q <= '0;
            par_q <= '0;
            stop2_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (!busy_o || tick) ? '0 : cnt + 1'b1;
            idx <= idx_n;
            stop_cnt <= stop_n;
            tx_o <= tx_n;
            if (pop) begin
                data_q <= mem[rd_ptr];
                len_q <= data_len_i;
                par_q <= parity_i;
                stop2_q <= stop2_i;
            end
        end
    end
    // Next state, FIFO pop and line level for the upcoming cycle
    always_comb begin
        state_n = state;
        idx_n = idx;
        stop_n = stop_cnt;
        pop = 1'b0;
        frame_done_o = 1'b0;
        case (state)
            IDLE: begin
                pop = tx_en_i && !empty;
                state_n = pop ? START : IDLE;
            end
            START: if (tick) begin
                state_n = DATA;
                idx_n = '0;
            end
            DATA: if (tick) begin
                if (idx == {1'b0, len_q} + 3'd4) begin
                    state_n = (par_q[0] ^ par_q[1]) ? PARITY : STOP;
                    stop_n = 1'b0;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            PARITY: if (tick) begin
                state_n = STOP;
                stop_n = 1'b0;
            end
            STOP: if (tick) begin
                if (stop_cnt == stop2_q) begin
                    frame_done_o = 1'b1;
                    pop = tx_en_i && !empty;
                    state_n = pop ? START : IDLE;
                end else begin
                    stop_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        tx_n = state_n == IDLE ? !break_i :
               state_n == START ? 1'b0 :
               state_n == DATA ? data_q[idx_n] :
               state_n == PARITY ? par_bit : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: directed self-checking bench for uart_tx_fifo_cfg
module tb_uart_tx_fifo_cfg;
    localparam int DEPTH = 16;
    logic clk = 1'b0, rst = 1'b1, tx_en = 1'b0, stop2 = 1'b0, brk = 1'b0, wr_valid = 1'b0;
    logic [15:0] baud_div = '0;
    logic [1:0] data_len = 2'd3, parity = 2'd0;
    logic [7:0] wr_data = '0;
    logic wr_ready, busy, frame_done, tx;
    logic [4:0] level;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .baud_div_i(baud_div),
        .data_len_i(data_len), .parity_i(parity), .stop2_i(stop2), .break_i(brk),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .level_o(level), .busy_o(busy), .frame_done_o(frame_done), .tx_o(tx)
    );

    function automatic logic exp_bit(input logic [7:0] b, input int len, input int par,
                                     input logic pb, input int i);
        if (i == 0) return 1'b0;
        if (i <= len) return b[i-1];
        if (i == len + 1 && (par == 1 || par == 2)) return pb;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] b);
        wr_valid = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b exp 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", frame_done); end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level got %0d exp 0", level); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
        rst = 1'b0;
    endtask

    // Runs nfr frames from the FIFO starting at the current negedge; checks every cycle
    task automatic run_frames(input string name, input int nfr, input int div, input int len,
                              input int par, input logic s2, input logic [23:0] bytes,
                              input logic [2:0] pbits, input int lvl0, input logic chg);
        int bl, nb, fl, fi, j;
        logic e;
        bl = div + 1;
        nb = 1 + len + ((par == 1 || par == 2) ? 1 : 0) + (s2 ? 2 : 1);
        fl = bl * nb;
        baud_div = 16'(div);
        data_len = 2'(len - 5);
        parity = 2'(par);
        stop2 = s2;
        tx_en = 1'b1;
        for (int k = 1; k <= nfr * fl + 1; k++) begin
            @(negedge clk);
            if (chg && k == 2) begin
                data_len = ~data_len;
                parity = (parity == 2'd0) ? 2'd1 : 2'd0;
                stop2 = !s2;
            end
            if (k <= nfr * fl) begin
                fi = (k - 1) / fl;
                j = ((k - 1) % fl) / bl;
                e = exp_bit(bytes[8*fi +: 8], len, par, pbits[fi], j);
                n_cmp++; if (tx !== e) begin n_bad++; $display("FAIL %s_tx cycle %0d got %b exp %b", name, k, tx, e); end
                n_cmp++; if (frame_done !== (k % fl == 0)) begin n_bad++; $display("FAIL %s_done cycle %0d got %b exp %b", name, k, frame_done, k % fl == 0); end
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy cycle %0d got %b exp 1", name, k, busy); end
                if ((k - 1) % fl == 0) begin
                    n_cmp++; if (level !== 5'(lvl0 - fi - 1)) begin n_bad++; $display("FAIL %s_level cycle %0d got %0d exp %0d", name, k, level, lvl0 - fi - 1); end
                end
            end else begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle_busy got %b exp 0", name, busy); end
                n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL %s_idle_tx got %b exp 1", name, tx); end
            end
        end
        tx_en = 1'b0;
    endtask

    task automatic test_basic_frame();
        push(8'h55);
        run_frames("basic", 1, 3, 8, 0, 1'b0, 24'h000055, 3'b000, 1, 1'b0);
    endtask

    task automatic test_parity();
        push(8'hA5);
        run_frames("even", 1, 1, 8, 1, 1'b0, 24'h0000A5, 3'b000, 1, 1'b0);
        push(8'hA5);
        run_frames("odd", 1, 1, 8, 2, 1'b0, 24'h0000A5, 3'b001, 1, 1'b0);
        push(8'h1F);
        run_frames("len5_even", 1, 1, 5, 1, 1'b0, 24'h00001F, 3'b001, 1, 1'b0);
        push(8'hE0);
        run_frames("len5_mask", 1, 0, 5, 1, 1'b0, 24'h0000E0, 3'b000, 1, 1'b0);
    endtask

    task automatic test_stop_and_none();
        push(8'h3C);
        run_frames("stop2", 1, 1, 8, 1, 1'b1, 24'h00003C, 3'b000, 1, 1'b0);
        push(8'h81);
        run_frames("par3_len7", 1, 2, 7, 3, 1'b0, 24'h000081, 3'b000, 1, 1'b0);
    endtask

    task automatic test_cfg_change();
        push(8'h96);
        run_frames("cfg_chg", 1, 1, 8, 0, 1'b0, 24'h000096, 3'b000, 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        push(8'h31);
        push(8'hC2);
        push(8'h7E);
        n_cmp++; if (level !== 5'd3) begin n_bad++; $display("FAIL b2b_level_pre got %0d exp 3", level); end
        run_frames("b2b", 3, 1, 8, 2, 1'b0, 24'h7EC231, 3'b100, 3, 1'b0);
    endtask

    task automatic test_fifo_full();
        baud_div = 16'd0;
        data_len = 2'd0;
        parity = 2'd0;
        stop2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        n_cmp++; if (level !== 5'(DEPTH)) begin n_bad++; $display("FAIL full_level got %0d exp %0d", level, DEPTH); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b exp 0", wr_ready); end
        push(8'hEE);
        n_cmp++; if (level !== 5'(DEPTH)) begin n_bad++; $display("FAIL full_drop got %0d exp %0d", level, DEPTH); end
        wr_valid = 1'b1;
        wr_data = 8'hDD;
        tx_en = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        n_cmp++; if (level !== 5'(DEPTH - 1)) begin n_bad++; $display("FAIL full_pop_drop got %0d exp %0d", level, DEPTH - 1); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after got %b exp 1", wr_ready); end
        repeat (6) @(negedge clk);
        n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL full_done got %b exp 1", frame_done); end
        wr_valid = 1'b1;
        wr_data = 8'hAB;
        @(negedge clk);
        wr_valid = 1'b0;
        tx_en = 1'b0;
        n_cmp++; if (level !== 5'(DEPTH - 1)) begin n_bad++; $display("FAIL push_pop_level got %0d exp %0d", level, DEPTH - 1); end
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_idle_busy got %b exp 0", busy); end
        n_cmp++; if (level !== 5'(DEPTH - 1)) begin n_bad++; $display("FAIL full_idle_level got %0d exp %0d", level, DEPTH - 1); end
    endtask

    task automatic test_reset_mid_frame();
        push(8'h00);
        push(8'h00);
        baud_div = 16'd3;
        data_len = 2'd3;
        parity = 2'd0;
        stop2 = 1'b0;
        tx_en = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_tx got %b exp 0", tx); end
        n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL mid_level got %0d exp 1", level); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_en = 1'b0;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx got %b exp 1", tx); end
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rst_mid_level got %0d exp 0", level); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got %b exp 1", wr_ready); end
    endtask

    task automatic test_break();
        brk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL break_tx cycle %0d got %b exp 0", i, tx); end
        end
        brk = 1'b0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL break_release got %b exp 1", tx); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_parity();
        test_stop_and_none();
        test_cfg_change();
        test_back_to_back();
        test_fifo_full();
        test_reset();
        test_reset_mid_frame();
        test_break();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
